// File: rtl/onehot_led_sequencer.sv
// rtl/onehot_led_sequencer.sv - registered one-hot LED decoder with up/down/bounce stepping engine
module onehot_led_sequencer #(
    parameter int SEL_W    = 4,
    parameter int PRESCALE = 25_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [1:0]              mode,
    input  logic [SEL_W-1:0]        sw,
    output logic [(1<<SEL_W)-1:0]   led,
    output logic [SEL_W-1:0]        pos,
    output logic                    tick
);
    localparam int OUT_W = 1 << SEL_W;
    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);
    localparam logic [SEL_W-1:0] POS_MAX = '1;
    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_UP     = 2'b01;
    localparam logic [1:0] MODE_DOWN   = 2'b10;
    localparam logic [1:0] MODE_BOUNCE = 2'b11;
    localparam logic [OUT_W-1:0] LED_ONE = OUT_W'(1);

    typedef enum logic {DIR_UP = 1'b0, DIR_DN = 1'b1} dir_t;

    dir_t               r_dir;
    logic [CNT_W-1:0]   r_cnt;
    logic [SEL_W-1:0]   r_pos;
    logic [OUT_W-1:0]   r_led;
    logic               r_tick;
    logic [1:0]         r_mode_q;

    logic [SEL_W-1:0]   w_pos_next;
    logic               w_step;

    assign w_step = (r_cnt == CNT_MAX);

    always_comb begin
        w_pos_next = r_pos;
        case (mode)
            MODE_UP:     w_pos_next = r_pos + SEL_W'(1);
            MODE_DOWN:   w_pos_next = r_pos - SEL_W'(1);
            MODE_BOUNCE: w_pos_next = (r_dir == DIR_DN) ? r_pos - SEL_W'(1) : r_pos + SEL_W'(1);
            default:     w_pos_next = r_pos;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pos    <= '0;
            r_led    <= LED_ONE;
            r_dir    <= DIR_UP;
            r_cnt    <= '0;
            r_tick   <= 1'b0;
            r_mode_q <= MODE_DIRECT;
        end else if (en) begin
            r_tick <= 1'b0;
            if (mode != r_mode_q) begin
                // Mode switch restarts the prescaler; pos is kept so walks start from the last DIRECT value
                r_mode_q <= mode;
                r_cnt    <= '0;
                if (mode == MODE_BOUNCE)
                    r_dir <= (r_pos == POS_MAX) ? DIR_DN : DIR_UP;
            end else if (mode == MODE_DIRECT) begin
                r_pos <= sw;
                r_led <= LED_ONE << sw;
                r_cnt <= '0;
            end else if (w_step) begin
                r_cnt  <= '0;
                r_tick <= 1'b1;
                r_pos  <= w_pos_next;
                r_led  <= LED_ONE << w_pos_next;
                if (mode == MODE_BOUNCE) begin
                    if (r_dir == DIR_UP && w_pos_next == POS_MAX)
                        r_dir <= DIR_DN;
                    else if (r_dir == DIR_DN && w_pos_next == '0)
                        r_dir <= DIR_UP;
                end
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign led  = r_led;
    assign pos  = r_pos;
    assign tick = r_tick;
endmodule

// File: tb/tb_onehot_led_sequencer.sv
// tb/tb_onehot_led_sequencer.sv - directed self-checking bench for onehot_led_sequencer
module tb_onehot_led_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [1:0]  mode = 2'b00;
    logic [3:0]  sw = 4'h0;
    logic [15:0] led, led1;
    logic [3:0]  pos, pos1;
    logic        tick, tick1;
    logic        chk_on = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    onehot_led_sequencer #(.SEL_W(4), .PRESCALE(4)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sw(sw),
        .led(led), .pos(pos), .tick(tick)
    );

    onehot_led_sequencer #(.SEL_W(4), .PRESCALE(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sw(sw),
        .led(led1), .pos(pos1), .tick(tick1)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (chk_on) begin
            n_cmp++;
            if (!$onehot(led) || !$onehot(led1) || led !== (16'h0001 << pos)) begin
                n_bad++;
                $display("FAIL onehot led=%h pos=%h led1=%h required one-hot of pos", led, pos, led1);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; mode = 2'b00; sw = 4'h0;
        step(2);
        n_cmp++; if (led !== 16'h0001 || pos !== 4'h0 || tick !== 1'b0) begin n_bad++;
            $display("FAIL reset led=%h pos=%h tick=%b required 0001/0/0", led, pos, tick); end
        n_cmp++; if (led1 !== 16'h0001 || pos1 !== 4'h0) begin n_bad++;
            $display("FAIL reset_p1 led=%h pos=%h required 0001/0", led1, pos1); end
        rst = 1'b0; chk_on = 1'b1;
        sw = 4'hA; step(1);
        n_cmp++; if (led !== 16'h0400 || pos !== 4'hA || tick !== 1'b0) begin n_bad++;
            $display("FAIL direct_a led=%h pos=%h tick=%b required 0400/a/0", led, pos, tick); end
        sw = 4'hF; step(1);
        n_cmp++; if (led !== 16'h8000) begin n_bad++;
            $display("FAIL direct_f led=%h required 8000", led); end
    endtask

    task automatic test_up;
        sw = 4'hE; step(1);
        mode = 2'b01; step(1);
        n_cmp++; if (pos !== 4'hE || tick !== 1'b0) begin n_bad++;
            $display("FAIL up_change pos=%h tick=%b required e/0", pos, tick); end
        step(3);
        n_cmp++; if (pos !== 4'hE || tick !== 1'b0) begin n_bad++;
            $display("FAIL up_hold pos=%h tick=%b required e/0", pos, tick); end
        step(1);
        n_cmp++; if (led !== 16'h8000 || tick !== 1'b1) begin n_bad++;
            $display("FAIL up_step led=%h tick=%b required 8000/1", led, tick); end
        step(1);
        n_cmp++; if (tick !== 1'b0 || pos !== 4'hF) begin n_bad++;
            $display("FAIL up_tick_pulse tick=%b pos=%h required 0/f", tick, pos); end
        step(3);
        n_cmp++; if (led !== 16'h0001 || tick !== 1'b1) begin n_bad++;
            $display("FAIL up_wrap led=%h tick=%b required 0001/1", led, tick); end
    endtask

    task automatic test_down_and_prescale1;
        mode = 2'b10; rst = 1'b1; step(1);
        rst = 1'b0; step(1);
        n_cmp++; if (pos !== 4'h0 || pos1 !== 4'h0 || tick1 !== 1'b0) begin n_bad++;
            $display("FAIL down_change pos=%h pos1=%h tick1=%b required 0/0/0", pos, pos1, tick1); end
        step(1);
        n_cmp++; if (pos1 !== 4'hF || tick1 !== 1'b1 || pos !== 4'h0) begin n_bad++;
            $display("FAIL p1_step1 pos1=%h tick1=%b pos=%h required f/1/0", pos1, tick1, pos); end
        step(1);
        n_cmp++; if (pos1 !== 4'hE || tick1 !== 1'b1) begin n_bad++;
            $display("FAIL p1_step2 pos1=%h tick1=%b required e/1", pos1, tick1); end
        step(1);
        n_cmp++; if (pos1 !== 4'hD || tick1 !== 1'b1) begin n_bad++;
            $display("FAIL p1_step3 pos1=%h tick1=%b required d/1", pos1, tick1); end
        step(1);
        n_cmp++; if (pos !== 4'hF || led !== 16'h8000 || tick !== 1'b1 || pos1 !== 4'hC) begin n_bad++;
            $display("FAIL down_wrap pos=%h led=%h tick=%b pos1=%h required f/8000/1/c", pos, led, tick, pos1); end
        step(4);
        n_cmp++; if (pos !== 4'hE) begin n_bad++;
            $display("FAIL down_step pos=%h required e", pos); end
    endtask

    task automatic test_bounce;
        logic [3:0] exp_seq [4];
        exp_seq[0] = 4'hE; exp_seq[1] = 4'hF; exp_seq[2] = 4'hE; exp_seq[3] = 4'hD;
        mode = 2'b00; sw = 4'hD; step(2);
        n_cmp++; if (pos !== 4'hD) begin n_bad++;
            $display("FAIL bounce_load pos=%h required d", pos); end
        mode = 2'b11; step(1);
        for (int k = 0; k < 4; k++) begin
            step(4);
            n_cmp++; if (pos !== exp_seq[k] || tick !== 1'b1) begin n_bad++;
                $display("FAIL bounce_seq%0d pos=%h tick=%b required %h/1", k, pos, tick, exp_seq[k]); end
        end
        step(52);
        n_cmp++; if (pos !== 4'h0) begin n_bad++;
            $display("FAIL bounce_bottom pos=%h required 0", pos); end
        step(4);
        n_cmp++; if (pos !== 4'h1) begin n_bad++;
            $display("FAIL bounce_turn pos=%h required 1", pos); end
    endtask

    task automatic test_enable;
        mode = 2'b01; step(1);
        step(2);
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            n_cmp++; if (pos !== 4'h1 || led !== 16'h0002 || tick !== 1'b0) begin n_bad++;
                $display("FAIL en_freeze%0d pos=%h led=%h tick=%b required 1/0002/0", k, pos, led, tick); end
        end
        en = 1'b1; step(1);
        n_cmp++; if (pos !== 4'h1 || tick !== 1'b0) begin n_bad++;
            $display("FAIL en_resume_wait pos=%h tick=%b required 1/0", pos, tick); end
        step(1);
        n_cmp++; if (pos !== 4'h2 || tick !== 1'b1) begin n_bad++;
            $display("FAIL en_resume_step pos=%h tick=%b required 2/1", pos, tick); end
        en = 1'b0; mode = 2'b10; step(3);
        en = 1'b1; step(1);
        n_cmp++; if (pos !== 4'h2 || tick !== 1'b0) begin n_bad++;
            $display("FAIL en_mode_change pos=%h tick=%b required 2/0", pos, tick); end
        step(3);
        n_cmp++; if (pos !== 4'h2) begin n_bad++;
            $display("FAIL en_mode_hold pos=%h required 2", pos); end
        step(1);
        n_cmp++; if (pos !== 4'h1 || tick !== 1'b1) begin n_bad++;
            $display("FAIL en_mode_step pos=%h tick=%b required 1/1", pos, tick); end
    endtask

    task automatic test_reset_mid_walk;
        mode = 2'b00; sw = 4'hF; step(2);
        mode = 2'b11; step(1);
        step(4);
        n_cmp++; if (pos !== 4'hE) begin n_bad++;
            $display("FAIL bounce_from_top pos=%h required e", pos); end
        rst = 1'b1; step(1);
        n_cmp++; if (pos !== 4'h0 || led !== 16'h0001 || tick !== 1'b0) begin n_bad++;
            $display("FAIL mid_reset pos=%h led=%h tick=%b required 0/0001/0", pos, led, tick); end
        rst = 1'b0; step(1);
        step(4);
        n_cmp++; if (pos !== 4'h1) begin n_bad++;
            $display("FAIL post_reset_dir pos=%h required 1", pos); end
        mode = 2'b01; step(1);
        step(2);
        mode = 2'b10; step(1);
        n_cmp++; if (pos !== 4'h1 || tick !== 1'b0) begin n_bad++;
            $display("FAIL midcount_change pos=%h tick=%b required 1/0", pos, tick); end
        step(3);
        n_cmp++; if (pos !== 4'h1 || tick !== 1'b0) begin n_bad++;
            $display("FAIL midcount_hold pos=%h tick=%b required 1/0", pos, tick); end
        step(1);
        n_cmp++; if (pos !== 4'h0 || tick !== 1'b1) begin n_bad++;
            $display("FAIL midcount_step pos=%h tick=%b required 0/1", pos, tick); end
    endtask

    initial begin
        #1;
        test_reset;
        test_up;
        test_down_and_prescale1;
        test_bounce;
        test_enable;
        test_reset_mid_walk;
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
